// File: rtl/cpu_pkg.sv
// Shared CPU types and constants used by the GPR write-port arbitration logic.
package cpu_pkg;

  localparam int         NUM_GPR = 16;
  localparam logic [3:0] RA_ADDR = 4'd15;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } rf_wr_req_t;

  function automatic logic [NUM_GPR-1:0] gpr_onehot(input logic [3:0] r);
    logic [NUM_GPR-1:0] v;
    v    = '0;
    v[r] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/rf_wr_fifo.sv
// Small circular buffer for out-of-band MDU results; exposes per-entry
// valid/address so the owner can build a pending-register mask.
module rf_wr_fifo
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  rf_wr_req_t            push_data,
  output rf_wr_req_t            head,
  output logic                  full,
  output logic                  empty,
  output logic [DEPTH-1:0]      ent_vld,
  output logic [DEPTH-1:0][3:0] ent_addr
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  rf_wr_req_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [DEPTH-1:0] vld_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
        vld_q[wr_ptr_q] <= 1'b1;
      end
      // Push and pop never target the same slot: that needs empty or full.
      if (do_pop) begin
        rd_ptr_q        <= ptr_inc(rd_ptr_q);
        vld_q[rd_ptr_q] <= 1'b0;
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_ent
    assign ent_vld[gi]  = vld_q[gi];
    assign ent_addr[gi] = mem_q[gi].addr;
  end

endmodule

// File: rtl/rf_wr_arbiter.sv
// Arbitrates the single GPR write port between writeback and buffered MDU
// results, bounding MDU starvation with a forced grant plus one Wb stall.
module rf_wr_arbiter
  import cpu_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  parameter int MAX_WAIT   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               wb_wr_en,
  input  logic [3:0]         wb_wr_addr,
  input  logic [31:0]        wb_wr_data,
  output logic               wb_stall,
  input  logic               mdu_vld,
  input  logic [3:0]         mdu_addr,
  input  logic [31:0]        mdu_data,
  output logic               mdu_rdy,
  output logic               rf_wr_en,
  output logic [3:0]         rf_wr_addr,
  output logic [31:0]        rf_wr_data,
  output logic [NUM_GPR-1:0] mdu_pend_mask
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  rf_wr_req_t                fifo_head;
  logic                      fifo_full, fifo_empty;
  logic [FIFO_DEPTH-1:0]     ent_vld;
  logic [FIFO_DEPTH-1:0][3:0] ent_addr;

  logic                      push, pop, grant_wb, head_due;
  logic [WAIT_W-1:0]         wait_q, wait_d;
  logic                      rf_en_q, rf_en_d;
  logic [3:0]                rf_addr_q, rf_addr_d;
  logic [31:0]               rf_data_q, rf_data_d;
  logic [NUM_GPR-1:0]        mask_q, mask_d;

  rf_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .push_data ('{addr: mdu_addr, data: mdu_data}),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_vld   (ent_vld),
    .ent_addr  (ent_addr)
  );

  always_comb begin
    head_due  = (wait_q == WAIT_W'(MAX_WAIT));
    pop       = start && !fifo_empty && (!wb_wr_en || head_due);
    grant_wb  = start && wb_wr_en && !pop;
    // Handshakes are forced low while reset is asserted.
    mdu_rdy   = rst && start && !fifo_full;
    wb_stall  = rst && wb_wr_en && (!start || pop);
    push      = mdu_vld && mdu_rdy;

    wait_d    = wait_q;
    rf_en_d   = pop || grant_wb;
    rf_addr_d = rf_addr_q;
    rf_data_d = rf_data_q;

    if (pop) begin
      wait_d    = '0;
      rf_addr_d = fifo_head.addr;
      rf_data_d = fifo_head.data;
    end else if (grant_wb) begin
      if (!fifo_empty && !head_due) wait_d = wait_q + WAIT_W'(1);
      rf_addr_d = wb_wr_addr;
      rf_data_d = wb_wr_data;
    end

    // Set from the push itself, cleared only once the entry has left the
    // FIFO, so the register stays pending through its write cycle.
    mask_d = push ? gpr_onehot(mdu_addr) : '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_vld[i]) mask_d = mask_d | gpr_onehot(ent_addr[i]);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_q    <= '0;
      rf_en_q   <= 1'b0;
      rf_addr_q <= '0;
      rf_data_q <= '0;
      mask_q    <= '0;
    end else begin
      wait_q    <= wait_d;
      rf_en_q   <= rf_en_d;
      rf_addr_q <= rf_addr_d;
      rf_data_q <= rf_data_d;
      mask_q    <= mask_d;
    end
  end

  assign rf_wr_en      = rf_en_q;
  assign rf_wr_addr    = rf_addr_q;
  assign rf_wr_data    = rf_data_q;
  assign mdu_pend_mask = mask_q;

endmodule

// File: tb/tb_rf_wr_arbiter.sv
// Directed bench for rf_wr_arbiter with hand-computed expectations.
module tb_rf_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        wb_wr_en;
  logic [3:0]  wb_wr_addr;
  logic [31:0] wb_wr_data;
  logic        wb_stall;
  logic        mdu_vld;
  logic [3:0]  mdu_addr;
  logic [31:0] mdu_data;
  logic        mdu_rdy;
  logic        rf_wr_en;
  logic [3:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [15:0] mdu_pend_mask;

  int errors = 0;
  int checks = 0;

  rf_wr_arbiter #(.FIFO_DEPTH(2), .MAX_WAIT(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .wb_wr_en      (wb_wr_en),
    .wb_wr_addr    (wb_wr_addr),
    .wb_wr_data    (wb_wr_data),
    .wb_stall      (wb_stall),
    .mdu_vld       (mdu_vld),
    .mdu_addr      (mdu_addr),
    .mdu_data      (mdu_data),
    .mdu_rdy       (mdu_rdy),
    .rf_wr_en      (rf_wr_en),
    .rf_wr_addr    (rf_wr_addr),
    .rf_wr_data    (rf_wr_data),
    .mdu_pend_mask (mdu_pend_mask)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rf(input string tag, input logic en, input logic [3:0] a, input logic [31:0] d);
    chk({tag, ".en"}, 32'(rf_wr_en), 32'(en));
    if (en) begin
      chk({tag, ".addr"}, 32'(rf_wr_addr), 32'(a));
      chk({tag, ".data"}, rf_wr_data, d);
    end
    $display("txn %s: rf_wr_en=%0b addr=%0d data=%h", tag, rf_wr_en, rf_wr_addr, rf_wr_data);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wb(input logic en, input logic [3:0] a, input logic [31:0] d);
    wb_wr_en = en; wb_wr_addr = a; wb_wr_data = d;
  endtask

  task automatic drive_mdu(input logic v, input logic [3:0] a, input logic [31:0] d);
    mdu_vld = v; mdu_addr = a; mdu_data = d;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
    drive_wb(1'b0, 4'd0, 32'h0);
    drive_mdu(1'b0, 4'd0, 32'h0);
    #3;
    chk("reset.rf_en", 32'(rf_wr_en), 32'd0);
    chk("reset.rf_addr", 32'(rf_wr_addr), 32'd0);
    chk("reset.rf_data", rf_wr_data, 32'd0);
    chk("reset.mask", 32'(mdu_pend_mask), 32'd0);
    chk("reset.rdy", 32'(mdu_rdy), 32'd0);
    chk("reset.stall", 32'(wb_stall), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Back-to-back Wb with empty FIFO: one-cycle delayed copy, never stalled
    start = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_wb(1'b1, 4'(8 + i), 32'h1000 + 32'(i));
      #1;
      chk("b2b.stall", 32'(wb_stall), 32'd0);
      tick();
      chk_rf("b2b.wr", 1'b1, 4'(8 + i), 32'h1000 + 32'(i));
    end
    drive_wb(1'b0, 4'd0, 32'h0);
    tick();
    chk_rf("b2b.idle", 1'b0, 4'd0, 32'h0);

    // Idle slot fill
    drive_mdu(1'b1, 4'd3, 32'hDEAD_BEEF);
    #1;
    chk("fill.rdy", 32'(mdu_rdy), 32'd1);
    tick();
    drive_mdu(1'b0, 4'd0, 32'h0);
    chk("fill.mask_c1", 32'(mdu_pend_mask), 32'h0008);
    chk_rf("fill.c1", 1'b0, 4'd0, 32'h0);
    tick();
    chk_rf("fill.c2", 1'b1, 4'd3, 32'hDEAD_BEEF);
    chk("fill.mask_c2", 32'(mdu_pend_mask), 32'h0008);
    tick();
    chk("fill.mask_c3", 32'(mdu_pend_mask), 32'h0);
    chk_rf("fill.c3", 1'b0, 4'd0, 32'h0);

    // Starvation: four lost cycles, then forced grant with one stall
    for (int k = 1; k <= 5; k++) begin
      drive_wb(1'b1, 4'(k), 32'hA0 + 32'(k));
      if (k == 1) drive_mdu(1'b1, 4'd5, 32'h55);
      else        drive_mdu(1'b0, 4'd0, 32'h0);
      #1;
      chk("starve.stall", 32'(wb_stall), 32'd0);
      tick();
      chk_rf("starve.wb", 1'b1, 4'(k), 32'hA0 + 32'(k));
      chk("starve.mask", 32'(mdu_pend_mask), 32'h0020);
    end
    drive_wb(1'b1, 4'd6, 32'hA6);
    #1;
    chk("starve.force_stall", 32'(wb_stall), 32'd1);
    tick();
    chk_rf("starve.mdu", 1'b1, 4'd5, 32'h55);
    chk("starve.no_restall", 32'(wb_stall), 32'd0);
    tick();
    chk_rf("starve.held_wb", 1'b1, 4'd6, 32'hA6);
    drive_wb(1'b0, 4'd0, 32'h0);
    tick();
    chk_rf("starve.idle", 1'b0, 4'd0, 32'h0);
    chk("starve.mask_clr", 32'(mdu_pend_mask), 32'h0);

    // Full FIFO
    drive_wb(1'b1, 4'd1, 32'hC1); drive_mdu(1'b1, 4'd9, 32'h99);
    #1; chk("full.rdy0", 32'(mdu_rdy), 32'd1);
    tick(); chk_rf("full.c0", 1'b1, 4'd1, 32'hC1);
    drive_wb(1'b1, 4'd2, 32'hC2); drive_mdu(1'b1, 4'd10, 32'hAA);
    #1; chk("full.rdy1", 32'(mdu_rdy), 32'd1);
    tick(); chk_rf("full.c1", 1'b1, 4'd2, 32'hC2);
    chk("full.mask", 32'(mdu_pend_mask), 32'h0600);
    drive_wb(1'b1, 4'd3, 32'hC3); drive_mdu(1'b1, 4'd11, 32'hBB);
    #1; chk("full.rdy_full", 32'(mdu_rdy), 32'd0);
    tick(); chk_rf("full.c2", 1'b1, 4'd3, 32'hC3);
    drive_wb(1'b1, 4'd4, 32'hC4);
    tick(); chk_rf("full.c3", 1'b1, 4'd4, 32'hC4);
    drive_wb(1'b1, 4'd5, 32'hC5);
    tick(); chk_rf("full.c4", 1'b1, 4'd5, 32'hC5);
    drive_wb(1'b1, 4'd6, 32'hC6);
    #1;
    chk("full.pop_stall", 32'(wb_stall), 32'd1);
    chk("full.pop_rdy", 32'(mdu_rdy), 32'd0);
    tick(); chk_rf("full.pop", 1'b1, 4'd9, 32'h99);
    chk("full.rdy_back", 32'(mdu_rdy), 32'd1);
    chk("full.stall_clr", 32'(wb_stall), 32'd0);
    tick(); chk_rf("full.held_wb", 1'b1, 4'd6, 32'hC6);
    drive_wb(1'b0, 4'd0, 32'h0); drive_mdu(1'b0, 4'd0, 32'h0);
    tick(); chk_rf("full.drain0", 1'b1, 4'd10, 32'hAA);
    tick(); chk_rf("full.drain1", 1'b1, 4'd11, 32'hBB);
    tick(); chk_rf("full.empty", 1'b0, 4'd0, 32'h0);

    // start=0 holds everything
    drive_wb(1'b1, 4'd2, 32'h22); drive_mdu(1'b1, 4'd12, 32'hCC);
    tick(); chk_rf("hold.c0", 1'b1, 4'd2, 32'h22);
    start = 1'b0;
    drive_wb(1'b1, 4'd4, 32'h44); drive_mdu(1'b1, 4'd13, 32'hDD);
    #1;
    chk("hold.stall", 32'(wb_stall), 32'd1);
    chk("hold.rdy", 32'(mdu_rdy), 32'd0);
    tick(); chk_rf("hold.c1", 1'b0, 4'd0, 32'h0);
    chk("hold.mask", 32'(mdu_pend_mask), 32'h1000);
    tick(); chk_rf("hold.c2", 1'b0, 4'd0, 32'h0);
    chk("hold.stall2", 32'(wb_stall), 32'd1);
    start = 1'b1;
    drive_mdu(1'b0, 4'd0, 32'h0);
    #1; chk("hold.resume_stall", 32'(wb_stall), 32'd0);
    tick(); chk_rf("hold.wb", 1'b1, 4'd4, 32'h44);
    drive_wb(1'b0, 4'd0, 32'h0);
    tick(); chk_rf("hold.mdu", 1'b1, 4'd12, 32'hCC);
    tick(); chk_rf("hold.idle", 1'b0, 4'd0, 32'h0);
    chk("hold.mask_clr", 32'(mdu_pend_mask), 32'h0);

    // Reset mid-FIFO
    drive_wb(1'b1, 4'd3, 32'h33); drive_mdu(1'b1, 4'd1, 32'h11);
    tick();
    drive_mdu(1'b1, 4'd2, 32'h22);
    tick();
    chk("rstmid.mask_pre", 32'(mdu_pend_mask), 32'h0006);
    drive_mdu(1'b0, 4'd0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid.rf_en", 32'(rf_wr_en), 32'd0);
    chk("rstmid.rf_addr", 32'(rf_wr_addr), 32'd0);
    chk("rstmid.rf_data", rf_wr_data, 32'd0);
    chk("rstmid.mask", 32'(mdu_pend_mask), 32'd0);
    chk("rstmid.rdy", 32'(mdu_rdy), 32'd0);
    chk("rstmid.stall", 32'(wb_stall), 32'd0);
    #1;
    rst = 1'b1;
    drive_wb(1'b0, 4'd0, 32'h0);
    tick(); chk_rf("rstmid.post0", 1'b0, 4'd0, 32'h0);
    tick(); chk_rf("rstmid.post1", 1'b0, 4'd0, 32'h0);
    chk("rstmid.mask_post", 32'(mdu_pend_mask), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
